// File: rtl/exp1_5_capture.sv
// Trigger-driven sample capture buffer: waits for non-zero sq_act, records DEPTH
// consecutive probe words into block RAM, then streams them out oldest first.
module exp1_5_capture #(
  parameter int DEPTH = 16,
  parameter int TW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    sq_c1,
  input  logic [7:0]    sq_x,
  input  logic [1:0]    sq_i,
  input  logic [7:0]    sq_act,
  input  logic          arm,
  input  logic          abort,
  input  logic          rd_en,
  output logic          busy,
  output logic          done,
  output logic [25:0]   rd_data,
  output logic          rd_valid,
  output logic [TW-1:0] trig_time
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q;
  logic [TW-1:0] trig_time_q;
  logic [AW-1:0] wr_idx_q;
  logic [AW-1:0] rd_ptr_q;
  logic [25:0]   rd_data_q;
  logic          rd_valid_q;
  logic          busy_q;
  logic          done_q;

  logic [25:0]   mem [DEPTH];
  logic [25:0]   sample;
  logic          trig;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign sample = {sq_i, sq_act, sq_x, sq_c1};
  assign trig   = (sq_act != 8'd0);

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (arm) state_d = ARMED;
        ARMED:   if (trig) state_d = CAPTURE;
        CAPTURE: if (wr_idx_q == LAST) state_d = DONE;
        DONE:    if (rd_en && rd_ptr_q == LAST) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Trigger word lands at index 0 on the same edge the trigger is seen.
  assign wr_en   = !rst && !abort && ((state_q == ARMED && trig) || state_q == CAPTURE);
  assign wr_addr = (state_q == ARMED) ? '0 : wr_idx_q;

  // Buffer has no reset so it maps onto block RAM; contents survive rst/abort.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      trig_time_q <= '0;
      wr_idx_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d == ARMED) || (state_d == CAPTURE);
      done_q     <= (state_d == DONE);
      rd_valid_q <= 1'b0;
      if (!abort) begin
        case (state_q)
          IDLE: if (arm) cnt_q <= '0;
          ARMED: begin
            if (trig) begin
              trig_time_q <= cnt_q;
              wr_idx_q    <= AW'(1);
            end else if (cnt_q != '1) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          CAPTURE: begin
            wr_idx_q <= wr_idx_q + 1'b1;
            if (wr_idx_q == LAST) rd_ptr_q <= '0;
          end
          DONE: begin
            if (rd_en) begin
              rd_data_q  <= mem[rd_ptr_q];
              rd_valid_q <= 1'b1;
              rd_ptr_q   <= rd_ptr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign trig_time = trig_time_q;

endmodule

// File: tb/tb_exp1_5_capture.sv
// Randomized scoreboard bench for exp1_5_capture: the model records the words driven
// from the trigger onward and expects them back in order on readout.
module tb_exp1_5_capture;

  localparam int DEPTH = 16;
  localparam int TW    = 16;

  logic          clk = 1'b0;
  logic          rst, arm, abort, rd_en;
  logic [25:0]   stim;
  logic          busy, done, rd_valid;
  logic [25:0]   rd_data;
  logic [TW-1:0] trig_time;

  always #5 clk = ~clk;

  exp1_5_capture #(.DEPTH(DEPTH), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .sq_c1(stim[7:0]), .sq_x(stim[15:8]), .sq_i(stim[25:24]), .sq_act(stim[23:16]),
    .arm(arm), .abort(abort), .rd_en(rd_en),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .trig_time(trig_time)
  );

  logic [25:0] sb_q[$];
  logic [25:0] cap_q[$];
  logic [25:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  longint      exp_trig = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every read word is popped and compared; idle cycles must hold rd_data.
  initial begin
    last_rd = '0;
    forever begin
      logic r;
      logic [25:0] e;
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        last_rd = '0;
      end else if (rd_valid) begin
        if (sb_q.size() == 0) begin
          chk("rd_unexpected", rd_valid, 0);
        end else begin
          e = sb_q.pop_front();
          chk("rd_data", rd_data, e);
          $display("read word %0h expected %0h", rd_data, e);
        end
        last_rd = rd_data;
      end else begin
        chk("rd_hold", rd_data, last_rd);
      end
    end
  end

  function automatic logic [25:0] idle_word();
    logic [25:0] w;
    w = 26'($urandom);
    w[23:16] = 8'd0;
    return w;
  endfunction

  // mode 0: random words; 1: act=1 with c1 counting from 0x10; 2: rd_en pulse while ARMED
  task automatic run_capture(input int n_idle, input int mode, input int n_samp);
    logic [25:0] w;
    cap_q.delete();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("armed_busy", busy, 1);
    for (int i = 0; i < n_idle; i++) begin
      stim = idle_word();
      rd_en = (mode == 2 && i == 1);
      @(negedge clk);
      if (mode == 2 && i == 1) chk("rd_in_armed_valid", rd_valid, 0);
      rd_en = 1'b0;
    end
    for (int k = 0; k < n_samp; k++) begin
      if (mode == 1) begin
        w = {2'($urandom), 8'h01, 8'($urandom), 8'(8'h10 + k)};
      end else begin
        w = 26'($urandom);
        if (k == 0) w[23:16] = 8'($urandom_range(1, 255));
      end
      stim = w;
      cap_q.push_back(w);
      if (k == 8) chk("capture_busy", busy, 1);
      @(negedge clk);
    end
    stim = idle_word();
    if (n_samp == DEPTH) begin
      exp_trig = (n_idle > 65535) ? 65535 : n_idle;
      chk("done_after_capture", done, 1);
      chk("busy_after_capture", busy, 0);
      chk("trig_time", trig_time, exp_trig);
      $display("capture idle=%0d trig_time=%0d expected %0d", n_idle, trig_time, exp_trig);
    end
  endtask

  task automatic readout(input bit with_arm);
    for (int k = 0; k < DEPTH; k++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk);
      if (with_arm && k == 3) begin
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("arm_in_done", done, 1);
      end
      rd_en = 1'b1;
      sb_q.push_back(cap_q[k]);
      @(negedge clk);
      rd_en = 1'b0;
    end
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("trig_time_hold", trig_time, exp_trig);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; rd_en = 1'b0; stim = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_time", trig_time, 0);
    rst = 1'b0;
    @(negedge clk);

    run_capture(4, 1, DEPTH);        // basic capture
    readout(1'b0);
    run_capture(0, 0, DEPTH);        // immediate trigger
    readout(1'b1);                   // arm ignored while reading
    run_capture(6, 2, DEPTH);        // rd_en ignored while armed
    readout(1'b0);

    run_capture(3, 0, DEPTH);        // abort beats rd_en in DONE
    abort = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    abort = 1'b0; rd_en = 1'b0;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_trig_hold", trig_time, exp_trig);

    run_capture(3, 0, 5);            // reset mid-capture
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_trig_time", trig_time, 0);
    run_capture(2, 0, DEPTH);
    readout(1'b0);

    for (int t = 0; t < 4; t++) begin
      run_capture($urandom_range(0, 20), 0, DEPTH);
      readout(t[0]);
    end

    run_capture(65600, 0, DEPTH);    // counter saturation
    readout(1'b0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
